// File: rtl/m_ext_pkg.sv
// RV32M decode constants and issue-controller state encoding shared by the
// M-unit issue path.
package m_ext_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      F3_MUL    = 3'd0,
      F3_MULH   = 3'd1,
      F3_MULHSU = 3'd2,
      F3_MULHU  = 3'd3,
      F3_DIV    = 3'd4,
      F3_DIVU   = 3'd5,
      F3_REM    = 3'd6,
      F3_REMU   = 3'd7
   } funct3_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      WB    = 3'd3,
      DRAIN = 3'd4
   } state_e;

   function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
      return (opcode == OPC_OP) && (funct7 == F7_MULDIV);
   endfunction

endpackage

// File: rtl/m_unit_issue_ctrl.sv
// Issue/writeback controller between the execute stage and the M unit:
// stalls execute, issues one RV32M op, and returns its result to the regfile.
module m_unit_issue_ctrl
   import m_ext_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            ex_valid,
   input  logic [31:0]     ex_instruction,
   input  logic [XLEN-1:0] ex_rs1_data,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic            ex_flush,
   output logic            ex_stall,
   output logic            ex_is_m,
   output logic            m_valid,
   output logic [31:0]     m_instruction,
   output logic [XLEN-1:0] m_rs1,
   output logic [XLEN-1:0] m_rs2,
   input  logic            m_wr,
   input  logic [XLEN-1:0] m_rd,
   input  logic            m_busy,
   input  logic            m_ready,
   output logic            wb_valid,
   output logic [4:0]      wb_rd_addr,
   output logic [XLEN-1:0] wb_data,
   input  logic            wb_ready,
   output logic            timeout_err
);

   localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_e          r_state, w_next;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_rs1, r_rs2, r_wb_data;
   logic [4:0]      r_rd;
   logic            w_accept, w_timeout, w_skip, w_done, w_waiting;

   assign ex_is_m   = is_m_op(ex_instruction[6:0], ex_instruction[31:25]);
   assign w_accept  = (r_state == IDLE) & ex_valid & ex_is_m & ~ex_flush & ~m_busy;
   assign w_waiting = (r_state == WAIT) | (r_state == DRAIN);
   assign w_timeout = w_waiting & ~m_ready & (r_cnt == CNT_LAST);
   // A result that would not be written (no write or rd==x0) retires straight from WAIT.
   assign w_skip    = (r_state == WAIT) & m_ready & (~m_wr | (r_rd == 5'd0));
   assign w_done    = ((r_state == WB) & wb_ready) | w_skip;

   assign ex_stall  = (ex_valid & ex_is_m & ~ex_flush & ~w_done) |
                      ((r_state == DRAIN) & ex_valid & ex_is_m);

   assign m_valid       = (r_state == ISSUE);
   assign m_instruction = r_instr;
   assign m_rs1         = r_rs1;
   assign m_rs2         = r_rs2;
   assign wb_valid      = (r_state == WB);
   assign wb_rd_addr    = r_rd;
   assign wb_data       = r_wb_data;
   assign timeout_err   = w_timeout;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (w_accept) w_next = ISSUE;
         ISSUE: w_next = ex_flush ? DRAIN : WAIT;
         // A flush that coincides with completion has nothing left to drain.
         WAIT: begin
            if (m_ready | w_timeout) w_next = (ex_flush | w_skip) ? IDLE : WB;
            else if (ex_flush)       w_next = DRAIN;
         end
         WB:    if (wb_ready | ex_flush) w_next = IDLE;
         DRAIN: if (m_ready | w_timeout) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_instr   <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_wb_data <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_instr <= ex_instruction;
            r_rs1   <= ex_rs1_data;
            r_rs2   <= ex_rs2_data;
            r_rd    <= ex_instruction[11:7];
         end
         if (r_state == ISSUE) r_cnt <= '0;
         else if (w_waiting)   r_cnt <= r_cnt + 1'b1;
         if (r_state == WAIT) begin
            if (m_ready)        r_wb_data <= m_rd;
            else if (w_timeout) r_wb_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_m_unit_issue_ctrl.sv
// Directed bench for m_unit_issue_ctrl with a behavioural RV32M unit model.
module tb_m_unit_issue_ctrl;
   import m_ext_pkg::*;

   localparam int XLEN = 32;
   localparam int TO   = 64;

   logic clk = 1'b0;
   logic resetn;
   logic ex_valid, ex_flush, ex_stall, ex_is_m;
   logic [31:0] ex_instruction, ex_rs1_data, ex_rs2_data;
   logic m_valid, m_wr, m_busy, m_ready;
   logic [31:0] m_instruction, m_rs1, m_rs2, m_rd;
   logic wb_valid, wb_ready, timeout_err;
   logic [4:0] wb_rd_addr;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;

   int stub_lat = 3;
   bit stub_hang = 1'b0;
   logic stub_busy;
   int stub_cnt;
   logic [31:0] stub_res;

   m_unit_issue_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .resetn(resetn),
      .ex_valid(ex_valid), .ex_instruction(ex_instruction),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_flush(ex_flush), .ex_stall(ex_stall), .ex_is_m(ex_is_m),
      .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2),
      .m_wr(m_wr), .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready),
      .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
      .wb_ready(wb_ready), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mres(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (ins[14:12])
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
      return {f7, 5'd2, 5'd1, f3, rd, opc};
   endfunction

   // M unit model: m_ready arrives stub_lat+1 cycles after the m_valid cycle.
   assign m_busy = stub_busy;
   assign m_wr   = 1'b1;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_ready <= 1'b0; m_rd <= '0; stub_busy <= 1'b0; stub_cnt <= 0; stub_res <= '0;
      end else begin
         m_ready <= 1'b0;
         if (m_valid) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_lat;
            stub_res  <= mres(m_instruction, m_rs1, m_rs2);
         end else if (stub_busy && !stub_hang) begin
            if (stub_cnt <= 1) begin
               m_ready <= 1'b1; m_rd <= stub_res; stub_busy <= 1'b0;
            end else stub_cnt <= stub_cnt - 1;
         end
      end
   end

   // Presents one op until the stall drops, then idles a few cycles; records what it saw.
   task automatic drive_op(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                           input int wb_hold,
                           output int mv_n, output int mv_at, output int mr_at, output int wb_n,
                           output int wb_hs, output int wb_at, output int done_at,
                           output int to_n, output int to_at,
                           output logic [31:0] wdat, output logic [4:0] waddr, output bit stable);
      bit done = 1'b0;
      int wbseen = 0;
      mv_n = 0; mv_at = -1; mr_at = -1; wb_n = 0; wb_hs = 0; wb_at = -1;
      done_at = -1; to_n = 0; to_at = -1; wdat = 'x; waddr = 'x; stable = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         ex_valid = !done; ex_instruction = instr; ex_rs1_data = a; ex_rs2_data = b; ex_flush = 1'b0;
         wb_ready = !(wb_valid && wbseen < wb_hold);
         @(negedge clk);
         if (m_valid) begin mv_n++; if (mv_at < 0) mv_at = c; end
         if (m_ready && mr_at < 0) mr_at = c;
         if (timeout_err) begin to_n++; if (to_at < 0) to_at = c; end
         if (wb_valid) begin
            if (wb_n == 0) begin wb_at = c; wdat = wb_data; waddr = wb_rd_addr; end
            else if (wb_data !== wdat || wb_rd_addr !== waddr) stable = 1'b0;
            wb_n++; wbseen++;
            if (wb_ready) wb_hs++;
         end
         if (!done && ex_valid && !ex_stall) begin done = 1'b1; done_at = c; end
         if (done && c >= done_at + 6) break;
      end
      ex_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; ex_valid = 1'b1; ex_flush = 1'b0; wb_ready = 1'b0;
      ex_instruction = mk(F7_MULDIV, F3_MUL, 5'd5, OPC_OP);
      ex_rs1_data = 32'h1234_5678; ex_rs2_data = 32'h9ABC_DEF0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({m_valid, wb_valid, timeout_err} !== 3'b000) begin errors++; $display("FAIL rst_ctrl got %b want 000", {m_valid, wb_valid, timeout_err}); end
      checks++; if (m_instruction !== 32'd0) begin errors++; $display("FAIL rst_m_instr got %h want 0", m_instruction); end
      checks++; if ({m_rs1, m_rs2} !== 64'd0) begin errors++; $display("FAIL rst_m_ops got %h want 0", {m_rs1, m_rs2}); end
      checks++; if (wb_data !== 32'd0 || wb_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_wb got %h/%0d want 0/0", wb_data, wb_rd_addr); end
      checks++; if (ex_is_m !== 1'b1 || ex_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got is_m=%b stall=%b want 1/1", ex_is_m, ex_stall); end
      ex_valid = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
   endtask

   task automatic test_mul();
      int mv_n, mv_at, mr_at, wb_n, wb_hs, wb_at, done_at, to_n, to_at; logic [31:0] d; logic [4:0] ad; bit st;
      drive_op(mk(F7_MULDIV, F3_MUL, 5'd5, OPC_OP), 32'h1111_FFFF, 32'h1111_FFFF, 0,
               mv_n, mv_at, mr_at, wb_n, wb_hs, wb_at, done_at, to_n, to_at, d, ad, st);
      checks++; if (mv_n !== 1 || mv_at !== 1) begin errors++; $display("FAIL mul_issue got n=%0d at=%0d want 1/1", mv_n, mv_at); end
      checks++; if (mr_at !== 5 || wb_at !== 6) begin errors++; $display("FAIL mul_latency got ready=%0d wb=%0d want 5/6", mr_at, wb_at); end
      checks++; if (wb_n !== 1 || wb_hs !== 1) begin errors++; $display("FAIL mul_wb_count got %0d/%0d want 1/1", wb_n, wb_hs); end
      checks++; if (d !== 32'hDDDC_0001 || ad !== 5'd5) begin errors++; $display("FAIL mul_wb_data got %h/%0d want ddDC0001/5", d, ad); end
      checks++; if (done_at !== 6) begin errors++; $display("FAIL mul_stall_drop got %0d want 6", done_at); end
   endtask

   task automatic test_div_backpressure();
      int mv_n, mv_at, mr_at, wb_n, wb_hs, wb_at, done_at, to_n, to_at; logic [31:0] d; logic [4:0] ad; bit st;
      drive_op(mk(F7_MULDIV, F3_DIV, 5'd7, OPC_OP), 32'hFFFF_FFF3, 32'd5, 3,
               mv_n, mv_at, mr_at, wb_n, wb_hs, wb_at, done_at, to_n, to_at, d, ad, st);
      checks++; if (d !== 32'hFFFF_FFFE || ad !== 5'd7) begin errors++; $display("FAIL div_wb_data got %h/%0d want fffffffe/7", d, ad); end
      checks++; if (wb_n !== 4 || wb_hs !== 1 || st !== 1'b1) begin errors++; $display("FAIL div_hold got cyc=%0d hs=%0d stable=%b want 4/1/1", wb_n, wb_hs, st); end
      checks++; if (done_at !== 9) begin errors++; $display("FAIL div_stall_drop got %0d want 9", done_at); end
   endtask

   task automatic test_remu_x0();
      int mv_n, mv_at, mr_at, wb_n, wb_hs, wb_at, done_at, to_n, to_at; logic [31:0] d; logic [4:0] ad; bit st;
      drive_op(mk(F7_MULDIV, F3_REMU, 5'd0, OPC_OP), 32'd13, 32'd0, 0,
               mv_n, mv_at, mr_at, wb_n, wb_hs, wb_at, done_at, to_n, to_at, d, ad, st);
      checks++; if (mv_n !== 1 || mr_at !== 5) begin errors++; $display("FAIL remu_issue got n=%0d ready=%0d want 1/5", mv_n, mr_at); end
      checks++; if (wb_n !== 0) begin errors++; $display("FAIL remu_no_wb got %0d want 0", wb_n); end
      checks++; if (done_at !== 5) begin errors++; $display("FAIL remu_stall_drop got %0d want 5", done_at); end
   endtask

   task automatic test_flush_drain();
      int mv_n = 0, mv1 = -1, mv2 = -1, wbv_n = 0, wb_at = -1, done_at = -1;
      logic s2 = 1'bx, s3 = 1'bx, s5 = 1'bx; logic [31:0] d = 'x; logic [4:0] ad = 'x; bit done = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk); #1;
         wb_ready = 1'b1;
         if (done) begin ex_valid = 1'b0; ex_flush = 1'b0; end
         else if (c <= 2) begin
            ex_valid = 1'b1; ex_instruction = mk(F7_MULDIV, F3_DIVU, 5'd9, OPC_OP);
            ex_rs1_data = 32'd13; ex_rs2_data = 32'd5; ex_flush = (c == 2);
         end else begin
            ex_valid = 1'b1; ex_instruction = mk(F7_MULDIV, F3_MULHU, 5'd10, OPC_OP);
            ex_rs1_data = 32'h0246_CA86; ex_rs2_data = 32'h8000_0000; ex_flush = 1'b0;
         end
         @(negedge clk);
         if (m_valid) begin mv_n++; if (mv_n == 1) mv1 = c; else mv2 = c; end
         if (wb_valid) begin wbv_n++; wb_at = c; d = wb_data; ad = wb_rd_addr; end
         if (c == 2) s2 = ex_stall;
         if (c == 3) s3 = ex_stall;
         if (c == 5) s5 = ex_stall;
         if (c >= 3 && !done && !ex_stall) begin done = 1'b1; done_at = c; end
         if (done && c >= done_at + 5) break;
      end
      ex_valid = 1'b0; ex_flush = 1'b0;
      checks++; if ({s2, s3, s5} !== 3'b011) begin errors++; $display("FAIL flush_stall got %b want 011", {s2, s3, s5}); end
      checks++; if (mv_n !== 2 || mv1 !== 1 || mv2 !== 7) begin errors++; $display("FAIL flush_issue got n=%0d at=%0d,%0d want 2 at 1,7", mv_n, mv1, mv2); end
      checks++; if (wbv_n !== 1 || wb_at !== 12) begin errors++; $display("FAIL flush_wb_count got %0d at %0d want 1 at 12", wbv_n, wb_at); end
      checks++; if (d !== 32'h0123_6543 || ad !== 5'd10) begin errors++; $display("FAIL flush_mulhu got %h/%0d want 01236543/10", d, ad); end
   endtask

   task automatic test_timeout();
      int mv_n, mv_at, mr_at, wb_n, wb_hs, wb_at, done_at, to_n, to_at; logic [31:0] d; logic [4:0] ad; bit st;
      stub_hang = 1'b1;
      drive_op(mk(F7_MULDIV, F3_MUL, 5'd6, OPC_OP), 32'd3, 32'd4, 0,
               mv_n, mv_at, mr_at, wb_n, wb_hs, wb_at, done_at, to_n, to_at, d, ad, st);
      checks++; if (to_n !== 1 || to_at !== TO + 1) begin errors++; $display("FAIL to_pulse got n=%0d at=%0d want 1 at %0d", to_n, to_at, TO + 1); end
      checks++; if (wb_hs !== 1 || wb_at !== TO + 2 || d !== 32'd0 || ad !== 5'd6) begin errors++; $display("FAIL to_wb got hs=%0d at=%0d d=%h a=%0d want 1 at %0d 0/6", wb_hs, wb_at, d, ad, TO + 2); end
      stub_hang = 1'b0;
      repeat (8) @(posedge clk);
      drive_op(mk(F7_MULDIV, F3_MUL, 5'd6, OPC_OP), 32'd3, 32'd4, 0,
               mv_n, mv_at, mr_at, wb_n, wb_hs, wb_at, done_at, to_n, to_at, d, ad, st);
      checks++; if (mv_at !== 1 || d !== 32'd12 || to_n !== 0) begin errors++; $display("FAIL to_recover got mv=%0d d=%h to=%0d want 1/0000000c/0", mv_at, d, to_n); end
   endtask

   task automatic test_async_reset();
      int wbv = 0;
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_flush = 1'b0; wb_ready = 1'b1;
      ex_instruction = mk(F7_MULDIV, F3_MUL, 5'd3, OPC_OP); ex_rs1_data = 32'd7; ex_rs2_data = 32'd9;
      repeat (3) @(posedge clk);
      #1 ex_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      checks++; if (m_instruction !== 32'd0 || m_rs1 !== 32'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL areset got instr=%h rs1=%h mv=%b want 0/0/0", m_instruction, m_rs1, m_valid); end
      @(posedge clk); #1 resetn = 1'b1;
      for (int c = 0; c < 10; c++) begin @(negedge clk); if (wb_valid) wbv++; end
      checks++; if (wbv !== 0) begin errors++; $display("FAIL areset_no_wb got %0d want 0", wbv); end
   endtask

   task automatic test_flush_idle();
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_flush = 1'b1; ex_instruction = mk(F7_MULDIV, F3_MUL, 5'd4, OPC_OP);
      #1;
      checks++; if (ex_is_m !== 1'b1 || ex_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got is_m=%b stall=%b want 1/0", ex_is_m, ex_stall); end
      @(posedge clk); #1 ex_valid = 1'b0; ex_flush = 1'b0;
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_issue got %b want 0", m_valid); end
   endtask

   task automatic test_non_m();
      int bad = 0, mv = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         ex_valid = 1'b1; ex_flush = 1'b0;
         ex_instruction = (c < 2) ? mk(7'b0000000, 3'd0, 5'd8, OPC_OP) : mk(F7_MULDIV, 3'd0, 5'd8, 7'b0111011);
         @(negedge clk);
         if (ex_is_m !== 1'b0 || ex_stall !== 1'b0) bad++;
         if (m_valid) mv++;
      end
      @(posedge clk); #1 ex_valid = 1'b0;
      @(negedge clk); if (m_valid) mv++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL non_m_decode got %0d bad cycles want 0", bad); end
      checks++; if (mv !== 0) begin errors++; $display("FAIL non_m_issue got %0d want 0", mv); end
   endtask

   initial begin
      ex_valid = 1'b0; ex_flush = 1'b0; wb_ready = 1'b0; resetn = 1'b0;
      ex_instruction = '0; ex_rs1_data = '0; ex_rs2_data = '0;
      test_reset();
      test_mul();
      test_div_backpressure();
      test_remu_x0();
      test_flush_drain();
      test_timeout();
      test_async_reset();
      test_flush_idle();
      test_non_m();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
